// File: rtl/lcd_write_if.sv
// Host-side write handshake plus the 4-bit HD44780 pin bundle.
// The engine takes the slave view; the host or testbench takes the master view.
interface lcd_write_if;
    logic [7:0] iData;
    logic       iRS;
    logic       iWrite;
    logic       oReady;
    logic       oInitDone;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_StrataFlashControl;
    logic       oLCD_ReadWrite;
    logic [3:0] oLCD_Data;

    modport master (
        output iData, iRS, iWrite,
        input  oReady, oInitDone, oLCD_Enabled, oLCD_RegisterSelect,
               oLCD_StrataFlashControl, oLCD_ReadWrite, oLCD_Data
    );

    modport slave (
        input  iData, iRS, iWrite,
        output oReady, oInitDone, oLCD_Enabled, oLCD_RegisterSelect,
               oLCD_StrataFlashControl, oLCD_ReadWrite, oLCD_Data
    );
endinterface

// File: rtl/lcd_write_engine.sv
// HD44780 4-bit write engine: autonomous power-up init and config, then
// serialises host bytes into two timed E strobes using one shared delay counter.
module lcd_write_engine #(
    parameter int CNT_W     = 20,
    parameter int T_POWERUP = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_SETUP   = 2,
    parameter int T_EN      = 12,
    parameter int T_HOLD    = 1,
    parameter int T_NIB     = 50,
    parameter int T_BYTE    = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic        Clock,
    input  logic        Reset,
    lcd_write_if.slave  bus
);

    typedef enum logic [2:0] {
        PWR_WAIT, NIB_SETUP, NIB_EN, NIB_HOLD, NIB_GAP, BYTE_WAIT, IDLE
    } state_e;

    // Steps 0..3 are single init nibbles (upper half of the byte), 4..7 are
    // config bytes, 8 means the sequence is finished and host writes are live.
    localparam logic [3:0] SEQ_LAST_INIT = 4'd3;
    localparam logic [3:0] SEQ_LAST_CFG  = 4'd7;
    localparam logic [3:0] SEQ_DONE      = 4'd8;

    function automatic logic [CNT_W-1:0] cyc(input int k);
        return CNT_W'(k - 1);
    endfunction

    function automatic logic [7:0] seq_byte(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: return 8'h30;
            4'd3:             return 8'h20;
            4'd4:             return 8'h28;
            4'd5:             return 8'h06;
            4'd6:             return 8'h0C;
            default:          return 8'h01;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] init_wait(input logic [3:0] idx);
        case (idx)
            4'd0:    return cyc(T_INIT1);
            4'd1:    return cyc(T_INIT2);
            default: return cyc(T_BYTE);
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       seq_q, seq_d;
    logic [7:0]       byte_q, byte_d;
    logic             lower_q, lower_d;
    logic [3:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             init_done_q, init_done_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= '0;
            seq_q       <= '0;
            byte_q      <= '0;
            lower_q     <= 1'b0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            byte_q      <= byte_d;
            lower_q     <= lower_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        byte_d      = byte_q;
        lower_d     = lower_q;
        data_d      = data_q;
        rs_d        = rs_q;
        en_d        = en_q;
        ready_d     = ready_q;
        init_done_d = init_done_q;

        case (state_q)
            // Counter leaves reset at 0, so the power-up wait counts up instead.
            PWR_WAIT: begin
                if (cnt_q == cyc(T_POWERUP)) begin
                    state_d = NIB_SETUP;
                    seq_d   = '0;
                    byte_d  = seq_byte(4'd0);
                    data_d  = byte_d[7:4];
                    rs_d    = 1'b0;
                    lower_d = 1'b0;
                    cnt_d   = cyc(T_SETUP);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NIB_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = NIB_EN;
                    en_d    = 1'b1;
                    cnt_d   = cyc(T_EN);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            NIB_EN: begin
                if (cnt_q == '0) begin
                    state_d = NIB_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = cyc(T_HOLD);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            NIB_HOLD: begin
                if (cnt_q == '0) begin
                    if (seq_q <= SEQ_LAST_INIT) begin
                        state_d = BYTE_WAIT;
                        cnt_d   = init_wait(seq_q);
                    end else if (!lower_q) begin
                        state_d = NIB_GAP;
                        cnt_d   = cyc(T_NIB);
                    end else begin
                        state_d = BYTE_WAIT;
                        cnt_d   = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02))
                                  ? cyc(T_CLEAR) : cyc(T_BYTE);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            NIB_GAP: begin
                if (cnt_q == '0) begin
                    state_d = NIB_SETUP;
                    lower_d = 1'b1;
                    data_d  = byte_q[3:0];
                    cnt_d   = cyc(T_SETUP);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BYTE_WAIT: begin
                if (cnt_q == '0) begin
                    if (seq_q >= SEQ_LAST_CFG) begin
                        state_d     = IDLE;
                        seq_d       = SEQ_DONE;
                        ready_d     = 1'b1;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = NIB_SETUP;
                        seq_d   = seq_q + 4'd1;
                        byte_d  = seq_byte(seq_d);
                        data_d  = byte_d[7:4];
                        rs_d    = 1'b0;
                        lower_d = 1'b0;
                        cnt_d   = cyc(T_SETUP);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IDLE: begin
                if (ready_q && bus.iWrite) begin
                    state_d = NIB_SETUP;
                    byte_d  = bus.iData;
                    rs_d    = bus.iRS;
                    data_d  = bus.iData[7:4];
                    lower_d = 1'b0;
                    ready_d = 1'b0;
                    cnt_d   = cyc(T_SETUP);
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    assign bus.oReady                  = ready_q;
    assign bus.oInitDone               = init_done_q;
    assign bus.oLCD_Enabled            = en_q;
    assign bus.oLCD_RegisterSelect     = rs_q;
    assign bus.oLCD_Data               = data_q;
    assign bus.oLCD_StrataFlashControl = 1'b1;
    assign bus.oLCD_ReadWrite          = 1'b0;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine with shortened sim timing; a negedge
// monitor logs every E pulse (nibble, RS, width) for the checks below.
module tb_lcd_write_engine;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    lcd_write_if bus();

    lcd_write_engine #(
        .CNT_W(20), .T_POWERUP(20), .T_INIT1(10), .T_INIT2(5), .T_SETUP(2),
        .T_EN(3), .T_HOLD(1), .T_NIB(4), .T_BYTE(8), .T_CLEAR(30)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] pn[$];
    logic       pr[$];
    int         pw[$];
    logic       prev_e = 1'b0;
    int         width = 0;
    logic [3:0] cur_n = '0;
    logic       cur_r = 1'b0;
    int         unstable = 0;

    always @(negedge Clock) begin
        if (bus.oLCD_Enabled) begin
            if (!prev_e) begin
                width = 1;
                cur_n = bus.oLCD_Data;
                cur_r = bus.oLCD_RegisterSelect;
            end else begin
                width++;
                if (bus.oLCD_Data !== cur_n || bus.oLCD_RegisterSelect !== cur_r)
                    unstable++;
            end
        end else if (prev_e) begin
            pn.push_back(cur_n);
            pr.push_back(cur_r);
            pw.push_back(width);
        end
        prev_e = bus.oLCD_Enabled;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_nibs();
        logic [63:0] v = '0;
        foreach (pn[i]) v = (v << 4) | 64'(pn[i]);
        return v;
    endfunction

    function automatic int bad_widths();
        int b = 0;
        foreach (pw[i]) if (pw[i] != 3) b++;
        return b;
    endfunction

    function automatic logic [63:0] pack_rs();
        logic [63:0] v = '0;
        foreach (pr[i]) v = (v << 1) | 64'(pr[i]);
        return v;
    endfunction

    task automatic clear_log();
        pn.delete();
        pr.delete();
        pw.delete();
    endtask

    // Called right after Reset drops (just past a negedge); optionally pokes iWrite
    // during the power-up wait, which must be ignored.
    task automatic check_init(input string tag, input bit poke);
        int n = 0;
        int early_e = 0;
        while (!bus.oReady && n < 1000) begin
            @(negedge Clock);
            n++;
            if (n <= 20 && bus.oLCD_Enabled) early_e++;
            if (poke && n == 5) begin bus.iWrite = 1'b1; bus.iData = 8'hFF; end
            if (poke && n == 6) bus.iWrite = 1'b0;
        end
        chk({tag, "_pwr_quiet"}, early_e, 0);
        chk({tag, "_ready_cycles"}, n, 193);
        chk({tag, "_pulse_count"}, pn.size(), 12);
        chk({tag, "_nibbles"}, pack_nibs(), 64'h333228060C01);
        chk({tag, "_rs"}, pack_rs(), 0);
        chk({tag, "_widths"}, bad_widths(), 0);
        chk({tag, "_initdone"}, bus.oInitDone, 1'b1);
    endtask

    task automatic write_byte(input string tag, input logic [7:0] d, input logic r,
                              input int exp_len, input int poke_at);
        int n = 0;
        @(negedge Clock);
        #1 clear_log();
        bus.iData = d;
        bus.iRS = r;
        bus.iWrite = 1'b1;
        @(negedge Clock);
        bus.iWrite = 1'b0;
        while (!bus.oReady && n < 500) begin
            n++;
            if (n == poke_at) begin bus.iWrite = 1'b1; bus.iData = 8'h99; end
            else bus.iWrite = 1'b0;
            @(negedge Clock);
        end
        bus.iWrite = 1'b0;
        chk({tag, "_busy_cycles"}, n, exp_len);
        chk({tag, "_pulse_count"}, pn.size(), 2);
        chk({tag, "_nibbles"}, pack_nibs(), {56'h0, d});
        chk({tag, "_rs"}, pack_rs(), r ? 2'b11 : 2'b00);
        chk({tag, "_widths"}, bad_widths(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        int n;
        bit dbl;
        bit prev_r;
        bus.iData = '0;
        bus.iRS = 1'b0;
        bus.iWrite = 1'b0;

        repeat (5) @(negedge Clock);
        chk("rst_en", bus.oLCD_Enabled, 1'b0);
        chk("rst_rs", bus.oLCD_RegisterSelect, 1'b0);
        chk("rst_data", bus.oLCD_Data, 4'h0);
        chk("rst_ready", bus.oReady, 1'b0);
        chk("rst_initdone", bus.oInitDone, 1'b0);
        chk("tie_flash", bus.oLCD_StrataFlashControl, 1'b1);
        chk("tie_rw", bus.oLCD_ReadWrite, 1'b0);
        #1 clear_log();
        @(negedge Clock);
        Reset = 1'b0;
        check_init("init", 1'b0);

        write_byte("w41", 8'h41, 1'b1, 24, 0);
        write_byte("clr01", 8'h01, 1'b0, 46, 0);
        write_byte("cmd80", 8'h80, 1'b0, 24, 0);
        write_byte("midpoke", 8'h55, 1'b1, 24, 10);

        // iWrite held high: one write per ready window, ready high one cycle each.
        @(negedge Clock);
        #1 clear_log();
        bus.iData = 8'h30;
        bus.iRS = 1'b1;
        bus.iWrite = 1'b1;
        highs = 0;
        dbl = 1'b0;
        prev_r = 1'b0;
        for (int i = 0; i < 75; i++) begin
            @(negedge Clock);
            if (bus.oReady) highs++;
            if (bus.oReady && prev_r) dbl = 1'b1;
            prev_r = bus.oReady;
        end
        bus.iWrite = 1'b0;
        chk("held_ready_windows", highs, 3);
        chk("held_no_double_ready", dbl, 1'b0);
        chk("held_pulse_count", pn.size(), 6);
        chk("held_nibbles", pack_nibs(), 64'h303030);
        chk("held_rs", pack_rs(), 6'b111111);
        @(negedge Clock);
        chk("held_stop_ready", bus.oReady, 1'b1);

        // Reset while E is high during a data write: outputs clear without an edge.
        @(negedge Clock);
        bus.iData = 8'h41;
        bus.iRS = 1'b1;
        bus.iWrite = 1'b1;
        @(negedge Clock);
        bus.iWrite = 1'b0;
        n = 0;
        while (!bus.oLCD_Enabled && n < 50) begin
            @(negedge Clock);
            n++;
        end
        chk("mid_en_reached", bus.oLCD_Enabled, 1'b1);
        #2 Reset = 1'b1;
        #1;
        chk("async_en", bus.oLCD_Enabled, 1'b0);
        chk("async_ready", bus.oReady, 1'b0);
        chk("async_initdone", bus.oInitDone, 1'b0);
        chk("async_data", {bus.oLCD_RegisterSelect, bus.oLCD_Data}, 5'h00);
        repeat (3) @(negedge Clock);
        #1 clear_log();
        @(negedge Clock);
        Reset = 1'b0;
        check_init("reinit", 1'b1);

        chk("data_stable_under_e", unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_write_engine.md
# lcd_write_engine

Parametrised HD44780-compatible character-LCD controller for the 4-bit bus on the starter board. It runs the power-on initialisation and configuration sequence autonomously. It then accepts byte writes from the MiniAlu datapath through a ready/write handshake and serialises each byte into two timed nibble strobes. All LCD timing is set through cycle-count parameters, so the same block serves any clock rate and runs with shortened timing in simulation.

## Interface
Parameters (defaults for a 50 MHz clock):
- CNT_W, 20: width of the shared delay counter; every T_* value must fit in CNT_W bits.
- T_POWERUP, 750000: idle cycles after reset before the first init nibble (15 ms).
- T_INIT1, 205000: wait after the first 0x3 nibble (4.1 ms).
- T_INIT2, 5000: wait after the second 0x3 nibble (100 us).
- T_SETUP, 2: cycles oLCD_Data/oLCD_RegisterSelect are stable before oLCD_Enabled rises; minimum 1.
- T_EN, 12: oLCD_Enabled high width; minimum 1.
- T_HOLD, 1: cycles data is held after oLCD_Enabled falls; minimum 1.
- T_NIB, 50: gap between the upper and lower nibble of a byte (1 us).
- T_BYTE, 2000: wait after a byte completes (40 us); also used after the third 0x3 and the 0x2 init nibbles.
- T_CLEAR, 82000: wait after a command byte 0x01 or 0x02 (1.64 ms); replaces T_BYTE.

Ports:
- Clock, in, 1: system clock; the block uses a single clock.
- Reset, in, 1: asynchronous, active-high reset.
- iData, in, 8: byte to write.
- iRS, in, 1: 0 = command, 1 = character data.
- iWrite, in, 1: write request; sampled only while oReady=1.
- oReady, out, 1: idle, initialisation complete, accepting a write.
- oInitDone, out, 1: init and config sequence finished; sticky until Reset.
- oLCD_Enabled, out, 1: LCD E strobe.
- oLCD_RegisterSelect, out, 1: LCD RS.
- oLCD_StrataFlashControl, out, 1: tied to 1 (StrataFlash disabled).
- oLCD_ReadWrite, out, 1: tied to 0 (write only).
- oLCD_Data, out, 4: LCD DB7..DB4.

## Operation
- While Reset is asserted and at its release: oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oReady=0, oInitDone=0, counter=0, state=PWR_WAIT.
- States and transitions:
  - PWR_WAIT for T_POWERUP cycles.
  - INIT sequence: nibbles 0x3 (wait T_INIT1), 0x3 (wait T_INIT2), 0x3 (wait T_BYTE), 0x2 (wait T_BYTE). All init nibbles use RS=0.
  - CFG sequence: command bytes 0x28, 0x06, 0x0C, 0x01. Each byte follows the normal byte path, including the T_CLEAR wait after 0x01.
  - IDLE.
  - Write path: NIB_SETUP, NIB_EN, NIB_HOLD, then NIB_GAP (upper nibble only), then the same three states for the lower nibble, then BYTE_WAIT, then IDLE.
- One nibble strobe is:
  - T_SETUP cycles with oLCD_Enabled=0 and data/RS valid,
  - then T_EN cycles with oLCD_Enabled=1,
  - then T_HOLD cycles with oLCD_Enabled=0 and data still held.
- Byte order: upper nibble (iData[7:4]) first, then lower nibble (iData[3:0]).
- On the first entry to IDLE, oInitDone rises together with oReady.
- Handshake:
  - A write is accepted on a rising edge where oReady=1 and iWrite=1. iData and iRS are captured into internal registers.
  - oReady falls on that same edge.
  - iWrite while oReady=0 is ignored and not queued. Holding iWrite high produces exactly one write per oReady window.
- Post-byte wait: T_CLEAR if the captured RS=0 and data is 0x01 or 0x02; otherwise T_BYTE.
- Between strobes, oLCD_Data and oLCD_RegisterSelect keep their last driven values.
- Reset asserted mid-operation: all outputs return to reset values asynchronously, and the full power-up sequence restarts.

## Timing
- Write latency: captured at edge N, so oLCD_Data/RS are valid from edge N+1. oLCD_Enabled is high for edges N+1+T_SETUP through N+T_SETUP+T_EN.
- Total write cycles, from acceptance to oReady=1: 2*(T_SETUP+T_EN+T_HOLD) + T_NIB + T_BYTE (or + T_CLEAR instead of T_BYTE).
- oReady may be 1 and accept a new write in the same cycle it rises; there are no dead cycles.
- The counter counts down to 0 with one-cycle granularity. A parameter value of k yields exactly k cycles in its state.
- oLCD_Enabled is a registered output with no glitches; it never rises while oLCD_Data or RS change in the same cycle.

## Test plan
Use sim parameters T_POWERUP=20, T_INIT1=10, T_INIT2=5, T_SETUP=2, T_EN=3, T_HOLD=1, T_NIB=4, T_BYTE=8, T_CLEAR=30 throughout.
- Reset for 5 cycles, then release -> oLCD_Enabled stays 0 for 20 cycles. Then E pulses of 3 cycles appear with nibbles 3,3,3,2, followed by config nibbles 2,8,0,6,0,C,0,1, all with RS=0. oInitDone=oReady=1 after the 0x01 wait of 30 cycles.
- After init, write iData=0x41, iRS=1 -> oReady=0 for 2*6+4+8=24 cycles. Data nibbles are 4 then 1, RS=1 during both E pulses, and each pulse lasts 3 cycles.
- Write command 0x01 -> oReady stays low for 12+4+30=46 cycles. A command 0x80 written next gives only 24 cycles.
- Hold iWrite=1 continuously with iData=0x30 -> back-to-back writes, one per oReady window, with no missed or duplicated byte. oReady is high for exactly 1 cycle between writes.
- Pulse iWrite during the power-up wait and mid-write -> ignored; no extra E pulses appear.
- Assert Reset during NIB_EN of a data write -> oLCD_Enabled=0 and oReady=0 immediately, not at the next edge. After release, the init sequence restarts from PWR_WAIT.
